// File: rtl/mem_req_issuer.sv
// Request FIFO plus a single-outstanding command sequencer for a simple memory controller.
// Request and response paths each add one register stage. req_ready falls when the FIFO is full.

module mem_req_fifo #(
    parameter int W     = 49,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dat,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    // Storage needs no reset: the head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_dat;
    end

    assign o_dat   = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

module mem_req_issuer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 12,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rdnwr,
    input  logic [15:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     cmd_n,
    output logic                     RDnWR,
    output logic [15:0]              Addr_in,
    output logic                     Data_in_vld,
    output logic [31:0]              Data_in,
    input  logic                     data_out_vld,
    input  logic [31:0]              Data_out,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int TMAX = (HOLD_CYCLES > RD_TIMEOUT) ? HOLD_CYCLES : RD_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WR_HOLD = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_CAPT = 3'd4;

    typedef struct packed {
        logic        rdnwr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [2:0]    r_state;
    logic [TW-1:0] r_cnt;
    logic          r_cmd_n;
    logic          r_rdnwr;
    logic [15:0]   r_addr;
    logic          r_dvld;
    logic [31:0]   r_wdata;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_data;
    logic          r_rsp_err;

    req_t          w_req;
    req_t          w_head;
    logic [CW-1:0] w_count;
    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_state_nxt;
    logic [TW-1:0] w_cnt_nxt;
    logic          w_rsp_to;
    logic          w_rsp_cap;

    assign w_req  = '{rdnwr: req_rdnwr, addr: req_addr, wdata: req_wdata};
    assign w_push = req_valid && req_ready;

    mem_req_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_dat   (w_req),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_count (w_count)
    );

    // The head entry is popped only on completion, so it stays stable for the whole transaction.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_rsp_to    = 1'b0;
        w_rsp_cap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_count != '0) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_head.rdnwr) begin
                    w_state_nxt = S_RD_WAIT;
                    w_cnt_nxt   = TW'(RD_TIMEOUT - 1);
                end else begin
                    w_state_nxt = S_WR_HOLD;
                    w_cnt_nxt   = TW'(HOLD_CYCLES - 1);
                end
            end
            S_WR_HOLD: begin
                if (r_cnt == '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - TW'(1);
                end
            end
            S_RD_WAIT: begin
                if (data_out_vld) begin
                    w_state_nxt = S_RD_CAPT;
                end else if (r_cnt == '0) begin
                    w_pop       = 1'b1;
                    w_rsp_to    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - TW'(1);
                end
            end
            S_RD_CAPT: begin
                // Controller presents registered Data_out one cycle after its valid strobe.
                w_pop       = 1'b1;
                w_rsp_cap   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_n     <= 1'b1;
            r_rdnwr     <= 1'b0;
            r_addr      <= '0;
            r_dvld      <= 1'b0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_n     <= (w_state_nxt != S_ISSUE);
            r_dvld      <= ((w_state_nxt == S_ISSUE) && !w_head.rdnwr) ||
                           (w_state_nxt == S_WR_HOLD);
            if (w_state_nxt == S_IDLE) begin
                r_rdnwr <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
            end else begin
                r_rdnwr <= w_head.rdnwr;
                r_addr  <= w_head.addr;
                r_wdata <= w_head.wdata;
            end
            r_rsp_valid <= w_rsp_to || w_rsp_cap;
            if (w_rsp_cap) begin
                r_rsp_data <= Data_out;
                r_rsp_err  <= 1'b0;
            end else if (w_rsp_to) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign req_ready   = (w_count != CW'(DEPTH));
    assign fifo_count  = w_count;
    assign busy        = (r_state != S_IDLE);
    assign cmd_n       = r_cmd_n;
    assign RDnWR       = r_rdnwr;
    assign Addr_in     = r_addr;
    assign Data_in_vld = r_dvld;
    assign Data_in     = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
endmodule

// File: tb/tb_mem_req_issuer.sv
// Directed bench for mem_req_issuer: write, read, timeout, full FIFO and mid-read reset.
module tb_mem_req_issuer;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_rdnwr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        cmd_n;
    logic        RDnWR;
    logic [15:0] Addr_in;
    logic        Data_in_vld;
    logic [31:0] Data_in;
    logic        data_out_vld;
    logic [31:0] Data_out;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  fifo_count;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [15:0] issue_q[$];
    logic        mon_en = 1'b0;
    int          rsp_seen = 0;
    int          cmd_seen = 0;

    mem_req_issuer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rdnwr    (req_rdnwr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .cmd_n        (cmd_n),
        .RDnWR        (RDnWR),
        .Addr_in      (Addr_in),
        .Data_in_vld  (Data_in_vld),
        .Data_in      (Data_in),
        .data_out_vld (data_out_vld),
        .Data_out     (Data_out),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .fifo_count   (fifo_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_n === 1'b0) issue_q.push_back(Addr_in);
        if (mon_en && rsp_valid === 1'b1) rsp_seen++;
        if (mon_en && cmd_n === 1'b0) cmd_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic rd, input logic [15:0] a, input logic [31:0] d,
                        output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_rdnwr = rd;
        req_addr  = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int w;
        int n;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_rdnwr    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        data_out_vld = 1'b0;
        Data_out     = '0;

        step();
        check("rst_cmd_n", cmd_n, 1);
        check("rst_dvld", Data_in_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        step();
        check("rst_ready", req_ready, 1);

        // Single write, with a stray data_out_vld that must be ignored.
        push(1'b0, 16'h3A5C, 32'hDEADBEEF, w);
        check("wr_idle_after_push", cmd_n, 1);
        check("wr_count1", fifo_count, 1);
        step();
        check("wr_issue_cmd_n", cmd_n, 0);
        check("wr_issue_addr", Addr_in, 32'h3A5C);
        check("wr_issue_dvld", Data_in_vld, 1);
        check("wr_issue_rdnwr", RDnWR, 0);
        check("wr_issue_data", Data_in, 32'hDEADBEEF);
        data_out_vld = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step();
            check("wr_hold_cmd_n", cmd_n, 1);
            check("wr_hold_dvld", Data_in_vld, 1);
            check("wr_hold_addr", Addr_in, 32'h3A5C);
            check("wr_hold_no_rsp", rsp_valid, 0);
        end
        data_out_vld = 1'b0;
        step();
        check("wr_done_dvld", Data_in_vld, 0);
        check("wr_done_busy", busy, 0);
        check("wr_done_count", fifo_count, 0);
        check("wr_done_addr", Addr_in, 0);
        check("wr_done_no_rsp", rsp_valid, 0);

        // Single read; data_out_vld sampled 5 cycles after the command cycle.
        push(1'b1, 16'h1004, 32'h0, w);
        step();
        check("rd_issue_cmd_n", cmd_n, 0);
        check("rd_issue_rdnwr", RDnWR, 1);
        check("rd_issue_dvld", Data_in_vld, 0);
        check("rd_issue_addr", Addr_in, 32'h1004);
        for (int j = 0; j < 4; j++) step();
        check("rd_wait_busy", busy, 1);
        data_out_vld = 1'b1;
        step();
        data_out_vld = 1'b0;
        Data_out     = 32'h12345678;
        check("rd_capt_no_rsp_yet", rsp_valid, 0);
        step();
        Data_out = 32'h0;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_data, 32'h12345678);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_count", fifo_count, 0);
        step();
        check("rd_rsp_pulse_end", rsp_valid, 0);
        check("rd_rsp_data_held", rsp_data, 32'h12345678);

        // Read timeout.
        push(1'b1, 16'h2222, 32'h0, w);
        step();
        check("to_issue_cmd_n", cmd_n, 0);
        for (int j = 0; j < 64; j++) step();
        check("to_last_wait_busy", busy, 1);
        check("to_last_wait_no_rsp", rsp_valid, 0);
        step();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_data", rsp_data, 0);
        check("to_count", fifo_count, 0);
        check("to_busy", busy, 0);
        step();
        check("to_rsp_pulse_end", rsp_valid, 0);

        // Full FIFO: nine back-to-back writes.
        issue_q.delete();
        for (int i = 0; i < 8; i++) push(1'b0, 16'h0100 + 16'(i), 32'(i), w);
        check("full_count8", fifo_count, 8);
        check("full_ready_low", req_ready, 0);
        push(1'b0, 16'h0108, 32'h8, w);
        check("full_9th_waited", 32'(w > 0), 1);
        check("full_count_after_9th", fifo_count, 8);
        n = 0;
        while (!(busy === 1'b0 && fifo_count === 4'd0) && n < 400) begin
            step();
            n++;
        end
        check("full_drain_in_time", 32'(n < 400), 1);
        check("full_issue_count", issue_q.size(), 9);
        for (int i = 0; i < 9 && i < issue_q.size(); i++)
            check("full_issue_order", issue_q[i], 16'h0100 + 16'(i));

        // Reset while a read waits with three more queued.
        for (int i = 0; i < 4; i++) push(1'b1, 16'h0A00 + 16'(i), 32'h0, w);
        check("mr_busy", busy, 1);
        check("mr_rdnwr", RDnWR, 1);
        check("mr_count", fifo_count, 4);
        #2 rst_n = 1'b0;
        #1;
        check("mr_cmd_n", cmd_n, 1);
        check("mr_dvld", Data_in_vld, 0);
        check("mr_rdnwr_rst", RDnWR, 0);
        check("mr_addr", Addr_in, 0);
        check("mr_data", Data_in, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_rsp_data", rsp_data, 0);
        check("mr_rsp_err", rsp_err, 0);
        check("mr_busy_rst", busy, 0);
        check("mr_count_rst", fifo_count, 0);
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        check("mr_ready", req_ready, 1);
        for (int j = 0; j < 100; j++) step();
        check("mr_no_rsp_after", rsp_seen, 0);
        check("mr_no_cmd_after", cmd_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
